trng_conditioner: RTL and testbench
===================================

Name: trng_conditioner

Overview:
- Downstream consumer of the ring-oscillator sampler's registered SIZE-bit raw output.
- Debiases each bit lane with a Von Neumann extractor and packs the surviving bits into SIZE-bit words.
- Runs a repetition-count health test on the raw stream.
- Buffers words in a small FIFO with a valid/ready output handshake toward the IO/bus side.

Parameters:
- SIZE, 8: raw sample width and output word width; one bit lane per oscillator pair.
- DEPTH, 4: output FIFO depth in words; power of two, at least 2.
- RPT_LIMIT, 32: number of consecutive identical raw samples that trips the health alarm; at least 2.

Ports:
- clk  input  1  sampling clock, the same clock that registers the raw samples.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  conditioner enable; normally tied to the oscillator enable.
- raw_in  input  SIZE  registered raw sample, one new sample per clk.
- out_data  output  SIZE  FIFO head word.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data on an edge where out_valid=1.
- alarm  output  1  sticky health-test failure.
- ovf  output  1  sticky flag: a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO emptied, pair phase=0, accumulator=0, bit count=0, repeat counter=0, alarm=0, ovf=0. Consequently out_valid=0 and out_data=0 immediately.
- en=0, at the next edge:
  - phase, accumulator, count and repeat counter are cleared; alarm and ovf are cleared.
  - FIFO contents are retained and remain drainable through the handshake.
- Pairing with en=1:
  - Phase toggles every cycle. The first en=1 edge is phase 0 and stores raw_in as the "first" sample.
  - The phase 1 edge evaluates each lane i as (first[i], raw_in[i]):
    - 10 gives bit 1; 01 gives bit 0.
    - 00 and 11 are discarded.
- Packing:
  - Accepted bits are appended in lane order 0 to SIZE-1 at accumulator position count, LSB-first.
  - The accumulator is 2*SIZE bits wide and count ranges 0 to 2*SIZE-1.
  - If count >= SIZE after appending, bits [SIZE-1:0] form a completed word on that same phase-1 edge. Remaining bits shift down and count decreases by SIZE.
- Latency: a completed word is written into the FIFO on its phase-1 edge. out_valid rises after that edge, i.e. 2 cycles after the first sample of the completing pair.
- FIFO:
  - Write on word completion; read when out_valid & out_ready.
  - Simultaneous read and write is allowed in any state, including full (read frees the slot, so the write succeeds) and empty (write proceeds; out_valid stays low that cycle).
  - Completion while full with no read: the word is dropped, ovf is set, and the accumulator still advances.
  - Read and write pointers wrap modulo DEPTH.
- out_data is stable while out_valid=1 and out_ready=0.
- Health test:
  - Repeat counter is set to 1 on the first en=1 sample.
  - It increments when raw_in equals the previous sample and resets to 1 otherwise. It saturates at RPT_LIMIT.
  - alarm is set on the edge that registers the RPT_LIMIT-th identical sample.
  - While alarm=1: no FIFO writes occur, accumulator and count are held at 0, and pairing continues but its output is ignored.
  - Only en=0 or reset clears alarm.

Optional Feature:
- Macro: TRNG_RAW_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit).
  - With bypass=1 and en=1, every raw_in is written to the FIFO directly each cycle. Extractor and accumulator are held cleared; the health test and ovf rules still apply.
  - Intended for characterising the oscillators.
- Not defined: no bypass port; output is always conditioned.

Test Plan:
- SIZE=8, en=1, raw_in pair (0xA5, 0x5A) -> out_valid rises 2 cycles after 0xA5; out_data=0xA5; count returns to 0.
- Pairs (0x0F,0x0F), (0xF0,0xF0) -> all bits discarded; out_valid stays 0; count=0.
- Pair (0x0F,0x00) then pair (0x00,0x0F) -> no word after the first pair (count=4); one word 0x0F after the second pair.
- out_ready=0 with 5 full-word pairs (0xFF,0x00) -> first 4 words stored, ovf=1 after the 5th. Then out_ready=1 -> exactly 4 reads of 0xFF, then out_valid=0.
- raw_in held at 0x3C for 32 cycles -> alarm=1 after the 32nd edge and no further writes. en=0 for one cycle -> alarm=0, and new pairs are conditioned again.
- Reset asserted mid-stream with 2 words buffered -> out_valid, alarm and ovf go 0 without a clock edge. After release, the first word requires a fresh complete pair sequence.

Source files
------------

// File: rtl/trng_conditioner.sv
// Von Neumann debiaser + repetition-count health test + output FIFO; TRNG_RAW_BYPASS_EN adds raw bypass.
// Latency: a word is written on the phase-1 edge of its completing pair; out_valid follows that edge.
// Backpressure: out_valid/out_ready; a word completing into a full FIFO with no read is dropped and ovf latches.
module trng_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module trng_conditioner #(
  parameter int SIZE      = 8,
  parameter int DEPTH     = 4,
  parameter int RPT_LIMIT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
`ifdef TRNG_RAW_BYPASS_EN
  input  logic            bypass,
`endif
  input  logic [SIZE-1:0] raw_in,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            alarm,
  output logic            ovf
);
  localparam int CW = $clog2(2*SIZE);
  localparam int RW = $clog2(RPT_LIMIT+1);

  logic              byp;
  logic              phase_q;
  logic [SIZE-1:0]   prev_q;
  logic [2*SIZE-1:0] acc_q, acc_v, acc_d;
  logic [CW-1:0]     cnt_q, cnt_v, cnt_d;
  logic [RW-1:0]     rpt_q, rpt_d;
  logic              alarm_q, ovf_q, alarm_set, hold;
  logic              word_done, wr_req, wr_en, rd_en;
  logic              fifo_full, fifo_empty;
  logic [SIZE-1:0]   wr_data, rd_data;

`ifdef TRNG_RAW_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  // rpt_q == 0 marks "no previous sample since enable".
  always_comb begin
    rpt_d = RW'(1);
    if (rpt_q != '0 && raw_in == prev_q)
      rpt_d = (rpt_q == RW'(RPT_LIMIT)) ? rpt_q : rpt_q + RW'(1);
  end

  assign alarm_set = (rpt_d == RW'(RPT_LIMIT));
  assign hold      = alarm_q | alarm_set;

  // On phase 1, prev_q holds the pair's first sample.
  always_comb begin
    acc_v = acc_q;
    cnt_v = cnt_q;
    for (int i = 0; i < SIZE; i++) begin
      if (prev_q[i] != raw_in[i]) begin
        acc_v[cnt_v] = prev_q[i];
        cnt_v        = cnt_v + CW'(1);
      end
    end
    word_done = phase_q && !byp && (cnt_v >= CW'(SIZE));
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (phase_q) begin
      acc_d = word_done ? (acc_v >> SIZE) : acc_v;
      cnt_d = word_done ? (cnt_v - CW'(SIZE)) : cnt_v;
    end
    if (hold || byp) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  assign rd_en   = out_valid & out_ready;
  assign wr_req  = en && !hold && (byp || word_done);
  assign wr_en   = wr_req && (!fifo_full || rd_en);
  assign wr_data = byp ? raw_in : acc_v[SIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      prev_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rpt_q   <= '0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!en) begin
      phase_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rpt_q   <= '0;
      alarm_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= byp ? 1'b0 : ~phase_q;
      prev_q  <= raw_in;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      if (alarm_set) alarm_q <= 1'b1;
      if (wr_req && fifo_full && !rd_en) ovf_q <= 1'b1;
    end
  end

  trng_fifo #(.W(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? '0 : rd_data;
  assign alarm     = alarm_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_trng_conditioner.sv
// Bench for trng_conditioner: scoreboard of expected words checked at each output handshake.
module tb_trng_conditioner;
  localparam int SIZE  = 8;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [SIZE-1:0] raw_in;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            alarm;
  logic            ovf;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [SIZE-1:0] exp_q [$];
  logic [15:0]     m_acc;
  int              m_cnt;
  bit              m_alarm;

  trng_conditioner #(.SIZE(SIZE), .DEPTH(DEPTH), .RPT_LIMIT(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .raw_in    (raw_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alarm     (alarm),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_word: got %h, expected no word", out_data);
      end else begin
        logic [SIZE-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL sb_word: got %h, expected %h", out_data, e);
        end
      end
    end
  end

  task automatic model_clear();
    m_acc = '0;
    m_cnt = 0;
  endtask

  task automatic drive_pair(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    raw_in = a;
    @(posedge clk); #1;
    raw_in = b;
    @(posedge clk); #1;
    for (int i = 0; i < SIZE; i++) begin
      if (a[i] != b[i]) begin
        m_acc[m_cnt] = a[i];
        m_cnt++;
      end
    end
    if (m_alarm) begin
      model_clear();
    end else if (m_cnt >= SIZE) begin
      if (exp_q.size() < DEPTH || out_ready) exp_q.push_back(m_acc[SIZE-1:0]);
      m_acc = m_acc >> SIZE;
      m_cnt = m_cnt - SIZE;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, expected 00", out_data); end
    checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL reset_alarm: got %b, expected 0", alarm); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b, expected 0", ovf); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_pair();
    en = 1'b1;
    out_ready = 1'b0;
    raw_in = 8'hA5;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL a5_early_valid: got %b, expected 0", out_valid); end
    raw_in = 8'h5A;
    @(posedge clk); #1;
    exp_q.push_back(8'hA5);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL a5_valid: got %b, expected 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin fails++; $display("FAIL a5_data: got %h, expected a5", out_data); end
    out_ready = 1'b1;
    drive_pair(8'h00, 8'h00);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL a5_drained: got %b, expected 0", out_valid); end
  endtask

  task automatic test_discard();
    drive_pair(8'h0F, 8'h0F);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL discard_0f: got %b, expected 0", out_valid); end
    drive_pair(8'hF0, 8'hF0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL discard_f0: got %b, expected 0", out_valid); end
  endtask

  task automatic test_half_words();
    drive_pair(8'h0F, 8'h00);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL half_no_word: got %b, expected 0", out_valid); end
    drive_pair(8'h00, 8'h0F);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL half_valid: got %b, expected 1", out_valid); end
    checks++; if (out_data !== 8'h0F) begin fails++; $display("FAIL half_data: got %h, expected 0f", out_data); end
    drive_pair(8'h00, 8'h00);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL half_drained: got %b, expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    int reads;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) drive_pair(8'hFF, 8'h00);
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b, expected 0", ovf); end
    checks++; if (out_data !== 8'hFF) begin fails++; $display("FAIL ovf_head_stable: got %h, expected ff", out_data); end
    drive_pair(8'hFF, 8'h00);
    checks++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b, expected 1", ovf); end
    en = 1'b0;
    out_ready = 1'b1;
    model_clear();
    reads = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) reads++;
      @(posedge clk); #1;
    end
    checks++; if (reads != 4) begin fails++; $display("FAIL ovf_read_count: got %0d, expected 4", reads); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got %b, expected 0", out_valid); end
    checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_cleared_by_en: got %b, expected 0", ovf); end
  endtask

  task automatic test_alarm();
    en = 1'b1;
    raw_in = 8'h3C;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      if (k == 31) begin
        checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL alarm_early: got %b, expected 0", alarm); end
      end
    end
    checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL alarm_set: got %b, expected 1", alarm); end
    m_alarm = 1'b1;
    model_clear();
    drive_pair(8'hA5, 8'h5A);
    drive_pair(8'hA5, 8'h5A);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL alarm_blocks_write: got %b, expected 0", out_valid); end
    checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL alarm_sticky: got %b, expected 1", alarm); end
    en = 1'b0;
    @(posedge clk); #1;
    checks++; if (alarm !== 1'b0) begin fails++; $display("FAIL alarm_clear: got %b, expected 0", alarm); end
    m_alarm = 1'b0;
    model_clear();
    en = 1'b1;
    drive_pair(8'hA5, 8'h5A);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL alarm_resume_valid: got %b, expected 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin fails++; $display("FAIL alarm_resume_data: got %h, expected a5", out_data); end
    drive_pair(8'h00, 8'h00);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_pair(8'hFF, 8'h00);
    drive_pair(8'hFF, 8'h00);
    raw_in = 8'hFF;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_buffered: got %b, expected 1", out_valid); end
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    model_clear();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin fails++; $display("FAIL mid_data: got %h, expected 00", out_data); end
    checks++; if (alarm !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL mid_flags: got alarm=%b ovf=%b, expected 0 0", alarm, ovf); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    raw_in = 8'hFF;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_phase: got %b, expected 0", out_valid); end
    raw_in = 8'h00;
    @(posedge clk); #1;
    exp_q.push_back(8'hFF);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL post_reset_valid: got %b, expected 1", out_valid); end
    checks++; if (out_data !== 8'hFF) begin fails++; $display("FAIL post_reset_data: got %h, expected ff", out_data); end
    out_ready = 1'b1;
    drive_pair(8'h00, 8'h00);
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d words pending, expected 0", exp_q.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    raw_in    = '0;
    out_ready = 1'b0;
    m_alarm   = 1'b0;
    model_clear();
    test_reset();
    test_basic_pair();
    test_discard();
    test_half_words();
    test_overflow();
    test_alarm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
